cache_ctrl: RTL

CACHE_CTRL -- requirements
Module: cache_ctrl

---
 rtl/cache_pkg.sv | 31 +++
 rtl/cache_if.sv | 68 ++++++
 rtl/cache_victim_rr.sv | 37 +++
 rtl/cache_ctrl.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cache_pkg
// Brief    : Shared sizing constants, FSM state type and helpers for the
//            cache controller slice.
// Revision : 1.0 - initial release
// ============================================================================
package cache_pkg;

  localparam int WIDTH    = 32;
  localparam int SET_BITS = 4;
  localparam int TAG_BITS = 26;
  localparam int WAYS     = 4;
  localparam int WAY_BITS = 2;
  localparam int CNT_BITS = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOOKUP = 3'd1,
    ST_MEM_RD = 3'd2,
    ST_MEM_WR = 3'd3,
    ST_RESP   = 3'd4
  } state_t;

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
    return (v == {CNT_BITS{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cache_if.sv
`default_nettype none
// ============================================================================
// Module   : cache_if
// Brief    : Bundle of CPU, tag/data array and memory signals around the
//            cache controller. Signal suffixes are from the controller's view.
//            slave  = controller side, master = surrounding system side.
// Revision : 1.0 - initial release
// ============================================================================
interface cache_if #(
  parameter int WIDTH    = cache_pkg::WIDTH,
  parameter int SET_BITS = cache_pkg::SET_BITS,
  parameter int TAG_BITS = cache_pkg::TAG_BITS,
  parameter int WAY_BITS = cache_pkg::WAY_BITS
);
  import cache_pkg::*;

  // CPU side
  logic                cpu_req_i;
  logic                cpu_we_i;
  logic [WIDTH-1:0]    cpu_addr_i;
  logic [WIDTH-1:0]    cpu_wdata_i;
  logic                cpu_stall_o;
  logic                cpu_valid_o;
  logic [WIDTH-1:0]    cpu_rdata_o;
  // Tag/data array side
  logic [SET_BITS-1:0] cache_set_o;
  logic [TAG_BITS-1:0] cache_tag_o;
  logic                cache_hit_i;
  logic [WAY_BITS-1:0] cache_hit_way_i;
  logic [WIDTH-1:0]    cache_rdata_i;
  logic                cache_fill_o;
  logic [WAY_BITS-1:0] cache_fill_way_o;
  logic [WIDTH-1:0]    cache_fill_data_o;
  // Memory side
  logic                mem_req_o;
  logic                mem_we_o;
  logic [WIDTH-1:0]    mem_addr_o;
  logic [WIDTH-1:0]    mem_wdata_o;
  logic                mem_ack_i;
  logic [WIDTH-1:0]    mem_rdata_i;
  // Statistics
  logic [15:0]         hit_count_o;
  logic [15:0]         miss_count_o;

  modport slave (
    input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
    output cpu_stall_o, cpu_valid_o, cpu_rdata_o,
    output cache_set_o, cache_tag_o,
    input  cache_hit_i, cache_hit_way_i, cache_rdata_i,
    output cache_fill_o, cache_fill_way_o, cache_fill_data_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_ack_i, mem_rdata_i,
    output hit_count_o, miss_count_o
  );

  modport master (
    output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
    input  cpu_stall_o, cpu_valid_o, cpu_rdata_o,
    input  cache_set_o, cache_tag_o,
    output cache_hit_i, cache_hit_way_i, cache_rdata_i,
    input  cache_fill_o, cache_fill_way_o, cache_fill_data_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_ack_i, mem_rdata_i,
    input  hit_count_o, miss_count_o
  );

endinterface
`default_nettype wire

// File: rtl/cache_victim_rr.sv
`default_nettype none
// ============================================================================
// Module   : cache_victim_rr
// Brief    : Per-set round-robin victim way pointer. Reports the way to
//            replace for the selected set and steps it on each advance.
// Revision : 1.0 - initial release
// ============================================================================
module cache_victim_rr #(
  parameter int SET_BITS = cache_pkg::SET_BITS,
  parameter int WAY_BITS = cache_pkg::WAY_BITS
) (
  input  wire logic                clk_i,
  input  wire logic                rst_i,
  input  wire logic [SET_BITS-1:0] i_set,
  input  wire logic                i_adv,
  output logic      [WAY_BITS-1:0] o_way
);

  localparam int SETS = 1 << SET_BITS;

  logic [WAY_BITS-1:0] r_ptr [SETS];

  // One pointer per set; wraps naturally because the way count is a power of two
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int s = 0; s < SETS; s++) begin
        r_ptr[s] <= '0;
      end
    end else if (i_adv) begin
      r_ptr[i_set] <= r_ptr[i_set] + 1'b1;
    end
  end

  assign o_way = r_ptr[i_set];

endmodule
`default_nettype wire

// File: rtl/cache_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cache_ctrl
// Brief    : Blocking set-associative cache controller. Write-through,
//            no-write-allocate; read misses fill a round-robin victim way.
//            Tag/data storage lives outside and answers lookups
//            combinationally from cache_set_o/cache_tag_o.
// Revision : 1.0 - initial release
// ============================================================================
module cache_ctrl #(
  parameter int WIDTH    = cache_pkg::WIDTH,
  parameter int SET_BITS = cache_pkg::SET_BITS,
  parameter int TAG_BITS = cache_pkg::TAG_BITS,
  parameter int WAYS     = cache_pkg::WAYS
) (
  input  wire logic clk_i,
  input  wire logic rst_i,
  cache_if.slave    bus
);
  import cache_pkg::*;

  localparam int WAY_BITS = $clog2(WAYS);
  localparam int SET_LSB  = 2;
  localparam int TAG_LSB  = SET_LSB + SET_BITS;

  state_t              r_state;
  state_t              w_next;

  logic [WIDTH-1:0]    r_addr;
  logic [WIDTH-1:0]    r_wdata;
  logic                r_we;
  logic [WIDTH-1:0]    r_rdata;
  logic [15:0]         r_hit_count;
  logic [15:0]         r_miss_count;

  logic [SET_BITS-1:0] w_set;
  logic [WAY_BITS-1:0] w_victim_way;
  logic                w_victim_adv;
  logic                w_fill;
  logic [WAY_BITS-1:0] w_fill_way;
  logic [WIDTH-1:0]    w_fill_data;
  logic                w_hit_inc;
  logic                w_miss_inc;
  logic                w_rdata_ld;
  logic [WIDTH-1:0]    w_rdata_nxt;
  logic                w_accept;

  assign w_set    = r_addr[SET_LSB +: SET_BITS];
  assign w_accept = (r_state == ST_IDLE) && bus.cpu_req_i;

  cache_victim_rr #(
    .SET_BITS (SET_BITS),
    .WAY_BITS (WAY_BITS)
  ) u_victim (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .i_set (w_set),
    .i_adv (w_victim_adv),
    .o_way (w_victim_way)
  );

  // State register; reset abandons any access in flight
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state plus the single-cycle strobes that accompany each transition
  always_comb begin
    w_next       = r_state;
    w_fill       = 1'b0;
    w_fill_way   = '0;
    w_fill_data  = '0;
    w_victim_adv = 1'b0;
    w_hit_inc    = 1'b0;
    w_miss_inc   = 1'b0;
    w_rdata_ld   = 1'b0;
    w_rdata_nxt  = '0;
    case (r_state)
      ST_IDLE: begin
        if (bus.cpu_req_i) w_next = ST_LOOKUP;
      end
      ST_LOOKUP: begin
        if (r_we) begin
          // Writes always go to memory; a hit also refreshes the cached copy
          w_next = ST_MEM_WR;
          if (bus.cache_hit_i) begin
            w_fill      = 1'b1;
            w_fill_way  = bus.cache_hit_way_i;
            w_fill_data = r_wdata;
            w_hit_inc   = 1'b1;
          end else begin
            w_miss_inc  = 1'b1;
          end
        end else if (bus.cache_hit_i) begin
          w_next      = ST_RESP;
          w_rdata_ld  = 1'b1;
          w_rdata_nxt = bus.cache_rdata_i;
          w_hit_inc   = 1'b1;
        end else begin
          w_next     = ST_MEM_RD;
          w_miss_inc = 1'b1;
        end
      end
      ST_MEM_RD: begin
        if (bus.mem_ack_i) begin
          w_next       = ST_RESP;
          w_fill       = 1'b1;
          w_fill_way   = w_victim_way;
          w_fill_data  = bus.mem_rdata_i;
          w_victim_adv = 1'b1;
          w_rdata_ld   = 1'b1;
          w_rdata_nxt  = bus.mem_rdata_i;
        end
      end
      ST_MEM_WR: begin
        if (bus.mem_ack_i) w_next = ST_RESP;
      end
      ST_RESP: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Request capture: address, direction and data are frozen for the whole access
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
    end else if (w_accept) begin
      r_addr  <= bus.cpu_addr_i;
      r_wdata <= bus.cpu_wdata_i;
      r_we    <= bus.cpu_we_i;
    end
  end

  // Read result holds until the next read completes
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rdata <= '0;
    end else if (w_rdata_ld) begin
      r_rdata <= w_rdata_nxt;
    end
  end

  // Hit/miss statistics, saturating at all-ones
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      if (w_hit_inc)  r_hit_count  <= sat_inc(r_hit_count);
      if (w_miss_inc) r_miss_count <= sat_inc(r_miss_count);
    end
  end

  assign bus.cpu_stall_o       = (r_state != ST_IDLE);
  assign bus.cpu_valid_o       = (r_state == ST_RESP);
  assign bus.cpu_rdata_o       = r_rdata;
  assign bus.cache_set_o       = w_set;
  assign bus.cache_tag_o       = r_addr[TAG_LSB +: TAG_BITS];
  assign bus.cache_fill_o      = w_fill;
  assign bus.cache_fill_way_o  = w_fill_way;
  assign bus.cache_fill_data_o = w_fill_data;
  assign bus.mem_req_o         = (r_state == ST_MEM_RD) || (r_state == ST_MEM_WR);
  assign bus.mem_we_o          = (r_state == ST_MEM_WR);
  assign bus.mem_addr_o        = r_addr;
  assign bus.mem_wdata_o       = r_wdata;
  assign bus.hit_count_o       = r_hit_count;
  assign bus.miss_count_o      = r_miss_count;

endmodule
`default_nettype wire
